// File: rtl/kettle_plant_model.sv
// rtl/kettle_plant_model.sv - cycle-level thermal/water plant model of a kettle
//
// Purpose: closes the loop around the kettle controller. Models heat-up,
// boiling with evaporation, dry-boil runaway, passive cooling and refill.
//
// Ports:
//   clk                 in  1  single clock, rising edge
//   rst_n               in  1  asynchronous active-low reset
//   heater              in  1  heater command from the controller
//   shutdown            in  1  safety shutdown, overrides heater
//   fill                in  1  level-sensitive refill tap
//   temperature_sensor  out 8  sensed temperature
//   water_level_sensor  out 1  high when level >= WATER_MIN
//   water_level         out 8  internal water level (debug/scoreboard)
//   plant_state         out 2  0 COOLING, 1 HEATING, 2 BOILING, 3 DRY
//   boiling             out 1  high while plant_state == BOILING
//
// Optional feature macro: KETTLE_SENSOR_NOISE_EN adds LFSR dither (+1/0/-1)
// to temperature_sensor; internal dynamics are unaffected.

module kettle_plant_model #(
  parameter logic [7:0] AMBIENT_TEMP  = 8'd25,
  parameter logic [7:0] BOIL_TEMP     = 8'd100,
  parameter int         HEAT_DIV      = 4,
  parameter int         COOL_DIV      = 16,
  parameter int         EVAP_DIV      = 64,
  parameter int         BOIL_EVAP_DIV = 16,
  parameter logic [7:0] WATER_INIT    = 8'd150,
  parameter logic [7:0] WATER_MAX     = 8'd200,
  parameter logic [7:0] WATER_MIN     = 8'd20,
  parameter logic [7:0] FILL_RATE     = 8'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       heater,
  input  logic       shutdown,
  input  logic       fill,
  output logic [7:0] temperature_sensor,
  output logic       water_level_sensor,
  output logic [7:0] water_level,
  output logic [1:0] plant_state,
  output logic       boiling
);

  typedef enum logic [1:0] {
    COOLING = 2'd0,
    HEATING = 2'd1,
    BOILING = 2'd2,
    DRY     = 2'd3
  } state_t;

  localparam int MAX_DIV = (EVAP_DIV > COOL_DIV) ?
                           ((EVAP_DIV > BOIL_EVAP_DIV) ? EVAP_DIV : BOIL_EVAP_DIV) :
                           ((COOL_DIV > HEAT_DIV) ? COOL_DIV : HEAT_DIV);
  localparam int CW = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1;

  localparam logic [CW-1:0] HEAT_LAST      = CW'(HEAT_DIV - 1);
  localparam logic [CW-1:0] COOL_LAST      = CW'(COOL_DIV - 1);
  localparam logic [CW-1:0] EVAP_LAST      = CW'(EVAP_DIV - 1);
  localparam logic [CW-1:0] BOIL_EVAP_LAST = CW'(BOIL_EVAP_DIV - 1);

  state_t        state, state_n;
  logic [7:0]    temp, temp_n;
  logic [7:0]    level, level_n;
  logic [CW-1:0] step_cnt, step_cnt_n;
  logic [CW-1:0] evap_cnt, evap_cnt_n;
  logic          heat_en;
  logic          evap_dec;
  logic [8:0]    level_sum;

  always_comb begin
    heat_en    = heater & ~shutdown;
    state_n    = state;
    temp_n     = temp;
    step_cnt_n = step_cnt;
    evap_cnt_n = evap_cnt;
    evap_dec   = 1'b0;

    // Transition priority: losing heat_en always wins.
    case (state)
      COOLING: if (heat_en) state_n = HEATING;
      HEATING: begin
        if (!heat_en)               state_n = COOLING;
        else if (level == 8'd0)     state_n = DRY;
        else if (temp >= BOIL_TEMP) state_n = BOILING;
      end
      BOILING: begin
        if (!heat_en)           state_n = COOLING;
        else if (level == 8'd0) state_n = DRY;
      end
      DRY: begin
        if (!heat_en)          state_n = COOLING;
        else if (level > 8'd0) state_n = HEATING;
      end
    endcase

    // A state change only clears the counters; dynamics resume next cycle.
    if (state_n != state) begin
      step_cnt_n = '0;
      evap_cnt_n = '0;
    end else begin
      case (state)
        COOLING: begin
          step_cnt_n = (step_cnt == COOL_LAST) ? '0 : step_cnt + 1'b1;
          if (step_cnt == COOL_LAST && temp > AMBIENT_TEMP) temp_n = temp - 8'd1;
        end
        HEATING: begin
          step_cnt_n = (step_cnt == HEAT_LAST) ? '0 : step_cnt + 1'b1;
          if (step_cnt == HEAT_LAST && temp != 8'hFF) temp_n = temp + 8'd1;
          evap_cnt_n = (evap_cnt == EVAP_LAST) ? '0 : evap_cnt + 1'b1;
          evap_dec   = (evap_cnt == EVAP_LAST);
        end
        BOILING: begin
          temp_n     = BOIL_TEMP;
          evap_cnt_n = (evap_cnt == BOIL_EVAP_LAST) ? '0 : evap_cnt + 1'b1;
          evap_dec   = (evap_cnt == BOIL_EVAP_LAST);
        end
        DRY: begin
          step_cnt_n = (step_cnt == HEAT_LAST) ? '0 : step_cnt + 1'b1;
          if (step_cnt == HEAT_LAST && temp != 8'hFF) temp_n = temp + 8'd1;
        end
      endcase
    end

    // Fill and evaporation combine first, then saturate to [0, WATER_MAX].
    level_sum = {1'b0, level} + {1'b0, (fill ? FILL_RATE : 8'd0)};
    if (evap_dec && level_sum != 9'd0) level_sum = level_sum - 9'd1;
    level_n = (level_sum > {1'b0, WATER_MAX}) ? WATER_MAX : level_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= COOLING;
      temp               <= AMBIENT_TEMP;
      level              <= WATER_INIT;
      step_cnt           <= '0;
      evap_cnt           <= '0;
      water_level        <= WATER_INIT;
      water_level_sensor <= (WATER_INIT >= WATER_MIN);
      boiling            <= 1'b0;
    end else begin
      state              <= state_n;
      temp               <= temp_n;
      level              <= level_n;
      step_cnt           <= step_cnt_n;
      evap_cnt           <= evap_cnt_n;
      water_level        <= level_n;
      water_level_sensor <= (level_n >= WATER_MIN);
      boiling            <= (state_n == BOILING);
    end
  end

  assign plant_state = state;

`ifdef KETTLE_SENSOR_NOISE_EN
  logic [7:0] lfsr;
  logic [9:0] noisy;
  logic [7:0] sensor_q;

  // Fibonacci LFSR, taps 8,6,5,4.
  always_comb begin
    noisy = {2'b00, temp_n} + {9'd0, lfsr[0]} - {9'd0, lfsr[1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= 8'hA5;
      sensor_q <= AMBIENT_TEMP;
    end else begin
      lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      // Bit 9 set means the sum wrapped below zero.
      if (noisy[9])      sensor_q <= 8'd0;
      else if (noisy[8]) sensor_q <= 8'hFF;
      else               sensor_q <= noisy[7:0];
    end
  end

  assign temperature_sensor = sensor_q;
`else
  assign temperature_sensor = temp;
`endif

endmodule

// File: tb/tb_kettle_plant_model.sv
// tb/tb_kettle_plant_model.sv - scoreboard bench for kettle_plant_model
module tb_kettle_plant_model;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       heater, shutdown, fill;
  logic [7:0] temperature_sensor;
  logic       water_level_sensor;
  logic [7:0] water_level;
  logic [1:0] plant_state;
  logic       boiling;

  kettle_plant_model dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .heater             (heater),
    .shutdown           (shutdown),
    .fill               (fill),
    .temperature_sensor (temperature_sensor),
    .water_level_sensor (water_level_sensor),
    .water_level        (water_level),
    .plant_state        (plant_state),
    .boiling            (boiling)
  );

  always #5 clk = ~clk;

  localparam int S_TEMP = 0, S_LEVEL = 1, S_WLS = 2, S_STATE = 3, S_BOIL = 4;

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event chk_now;

  function automatic int observe(int sel);
    case (sel)
      S_TEMP:  return int'(temperature_sensor);
      S_LEVEL: return int'(water_level);
      S_WLS:   return int'(water_level_sensor);
      S_STATE: return int'(plant_state);
      default: return int'(boiling);
    endcase
  endfunction

  // Monitor: drains the scoreboard on the falling edge, or at once on request.
  initial begin
    forever begin
      @(negedge clk or chk_now);
      while (q.size() > 0) begin
        exp_t e;
        int   act;
        e   = q.pop_front();
        act = observe(e.sel);
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input int v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_reset(input string tag);
    expect_val({tag, "_temp"},  S_TEMP,  25);
    expect_val({tag, "_level"}, S_LEVEL, 150);
    expect_val({tag, "_wls"},   S_WLS,   1);
    expect_val({tag, "_state"}, S_STATE, 0);
    expect_val({tag, "_boil"},  S_BOIL,  0);
  endtask

  // Heat from a fresh reset release until the first BOILING edge.
  task automatic heat_to_boil(input string tag);
    heater = 1'b1; shutdown = 1'b0; fill = 1'b0;
    rst_n  = 1'b1;
    tick(1);
    expect_val({tag, "_heating"}, S_STATE, 1);
    tick(3);
    expect_val({tag, "_t_before_step"}, S_TEMP, 25);
    tick(1);
    expect_val({tag, "_t_first_step"}, S_TEMP, 26);
    tick(296);
    expect_val({tag, "_t100"},   S_TEMP,  100);
    expect_val({tag, "_lvl146"}, S_LEVEL, 146);
    expect_val({tag, "_still_heating"}, S_STATE, 1);
    tick(1);
    expect_val({tag, "_boil_state"}, S_STATE, 2);
    expect_val({tag, "_boil_flag"},  S_BOIL,  1);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $finish;
  end

  initial begin
    rst_n = 1'b0; heater = 1'b1; shutdown = 1'b0; fill = 1'b1;
    tick(2);
    expect_reset("rst0");
    ->chk_now;
    tick(1);
    fill = 1'b0;

    // Heat-up into boiling, then boil dry.
    heat_to_boil("hu");
    tick(16);
    expect_val("boil_lvl145", S_LEVEL, 145);
    expect_val("boil_t_held", S_TEMP,  100);
    tick(2000);
    expect_val("lvl20", S_LEVEL, 20);
    expect_val("wls_at20", S_WLS, 1);
    tick(16);
    expect_val("lvl19", S_LEVEL, 19);
    expect_val("wls_at19", S_WLS, 0);
    tick(304);
    expect_val("lvl0", S_LEVEL, 0);
    expect_val("lvl0_still_boil", S_STATE, 2);
    tick(1);
    expect_val("dry_state", S_STATE, 3);
    expect_val("dry_boil_flag", S_BOIL, 0);
    tick(40);
    expect_val("dry_t110", S_TEMP, 110);
    tick(580);
    expect_val("dry_t255", S_TEMP, 255);
    tick(8);
    expect_val("dry_t_sat", S_TEMP, 255);

    // Refill out of DRY.
    fill = 1'b1;
    tick(1);
    expect_val("dry_fill_lvl2", S_LEVEL, 2);
    fill = 1'b0;
    tick(1);
    expect_val("dry_fill_heating", S_STATE, 1);
    heater = 1'b0;
    tick(1);
    expect_val("heater_off_cool", S_STATE, 0);

    // Reset mid-count during BOILING.
    rst_n = 1'b0;
    tick(1);
    heat_to_boil("hu2");
    tick(7);
    #1;
    rst_n = 1'b0;
    #1;
    expect_reset("rst_mid");
    ->chk_now;
    tick(1);

    // Shutdown override from BOILING, cooling down to ambient.
    heat_to_boil("hu3");
    tick(16);
    expect_val("pre_sd_lvl145", S_LEVEL, 145);
    shutdown = 1'b1;
    tick(1);
    expect_val("sd_cool", S_STATE, 0);
    expect_val("sd_t100", S_TEMP, 100);
    tick(16);
    expect_val("cool_t99", S_TEMP, 99);
    tick(1184);
    expect_val("cool_t25", S_TEMP, 25);
    tick(32);
    expect_val("cool_floor", S_TEMP, 25);
    expect_val("cool_no_evap", S_LEVEL, 145);

    // Fill saturation in COOLING.
    fill = 1'b1;
    tick(25);
    expect_val("fill_195", S_LEVEL, 195);
    tick(1);
    expect_val("fill_197", S_LEVEL, 197);
    tick(1);
    expect_val("fill_199", S_LEVEL, 199);
    tick(1);
    expect_val("fill_200", S_LEVEL, 200);
    tick(1);
    expect_val("fill_hold", S_LEVEL, 200);
    expect_val("fill_temp", S_TEMP, 25);
    fill = 1'b0;

    tick(2);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
